alu_exec_sequencer: RTL and testbench

Multi-cycle controller that sequences the combinational data-processing ALU for one ARM data-processing instruction at a time. It accepts a decoded command over a valid/ready handshake and evaluates the condition code against its internal CPSR flags. It then drives the ALU opcode, operands, S and output-enable, captures the result, writes the register file and updates the NZCV flags. It sits between the decode stage and the ALU/register-file pair and owns the architectural flags register.

---
 rtl/alu_seq_pkg.sv | 67 ++++++
 rtl/arm_cond_eval.sv | 39 +++
 rtl/alu_exec_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, opcode and condition encodings for alu_exec_sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COND = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } seq_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] ARM_AND = 4'b0000;
  localparam logic [3:0] ARM_EOR = 4'b0001;
  localparam logic [3:0] ARM_SUB = 4'b0010;
  localparam logic [3:0] ARM_RSB = 4'b0011;
  localparam logic [3:0] ARM_ADD = 4'b0100;
  localparam logic [3:0] ARM_ADC = 4'b0101;
  localparam logic [3:0] ARM_SBC = 4'b0110;
  localparam logic [3:0] ARM_RSC = 4'b0111;
  localparam logic [3:0] ARM_TST = 4'b1000;
  localparam logic [3:0] ARM_TEQ = 4'b1001;
  localparam logic [3:0] ARM_CMP = 4'b1010;
  localparam logic [3:0] ARM_CMN = 4'b1011;
  localparam logic [3:0] ARM_ORR = 4'b1100;
  localparam logic [3:0] ARM_MOV = 4'b1101;
  localparam logic [3:0] ARM_BIC = 4'b1110;
  localparam logic [3:0] ARM_MVN = 4'b1111;

  localparam logic [4:0] ALU_OP_MOV = 5'b10000;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Every ARM opcode maps straight through except MOV, which uses the ALU's B-bypass op.
  function automatic logic [4:0] map_alu_op(input logic [3:0] op);
    return (op == ARM_MOV) ? ALU_OP_MOV : {1'b0, op};
  endfunction

  // TST/TEQ/CMP/CMN occupy 10xx.
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // Arithmetic ops take all four flags from the ALU; logical ops keep V and use the shifter carry.
  function automatic logic is_arith(input logic [3:0] op);
    return (op inside {ARM_SUB, ARM_RSB, ARM_ADD, ARM_ADC, ARM_SBC, ARM_RSC, ARM_CMP, ARM_CMN});
  endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// rtl/arm_cond_eval.sv - ARM condition-field evaluation against NZCV flags
module arm_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the condition field; NV never passes.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - sequences one ARM data-processing op through the ALU and owns CPSR
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [3:0]    CMD_COND,
  input  logic [3:0]    CMD_OPCODE,
  input  logic          CMD_S,
  input  logic [RW-1:0] CMD_RD,
  input  logic [DW-1:0] CMD_A,
  input  logic [DW-1:0] CMD_B,
  input  logic          CMD_SHIFT_C,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  output logic [4:0]    ALU_OP,
  output logic          ALU_S,
  output logic          ALU_OUT_EN,
  output logic [3:0]    ALU_FLAGS_IN,
  input  logic [DW-1:0] ALU_RESULT,
  input  logic [3:0]    ALU_FLAGS_OUT,
  output logic          RF_WE,
  output logic [RW-1:0] RF_WADDR,
  output logic [DW-1:0] RF_WDATA,
  output logic [3:0]    CPSR,
  output logic          DONE,
  output logic          SKIPPED
);

  seq_state_t    state_q, state_d;
  logic [3:0]    cpsr_q, cpsr_d;
  logic [3:0]    cond_q, op_q;
  logic          s_q, shc_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] a_q, b_q;
  logic          cond_pass;

  arm_cond_eval u_cond (
    .cond_i  (cond_q),
    .flags_i (cpsr_q),
    .pass_o  (cond_pass)
  );

  // State and flags register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cpsr_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cpsr_q  <= cpsr_d;
    end
  end

  // Command capture on the accepting handshake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q <= '0;
      op_q   <= '0;
      s_q    <= 1'b0;
      shc_q  <= 1'b0;
      rd_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (CMD_VALID && CMD_READY) begin
      cond_q <= CMD_COND;
      op_q   <= CMD_OPCODE;
      s_q    <= CMD_S;
      shc_q  <= CMD_SHIFT_C;
      rd_q   <= CMD_RD;
      a_q    <= CMD_A;
      b_q    <= CMD_B;
    end
  end

  assign CPSR         = cpsr_q;
  assign ALU_FLAGS_IN = cpsr_q;

  // Next-state, ALU drive, writeback and flag-update decode.
  always_comb begin
    state_d    = state_q;
    cpsr_d     = cpsr_q;
    CMD_READY  = 1'b0;
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_OP     = '0;
    ALU_S      = 1'b0;
    ALU_OUT_EN = 1'b0;
    RF_WE      = 1'b0;
    RF_WADDR   = '0;
    RF_WDATA   = '0;
    DONE       = 1'b0;
    SKIPPED    = 1'b0;
    case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) state_d = S_COND;
      end
      S_COND: begin
        if (cond_pass) begin
          state_d = S_EXEC;
        end else begin
          DONE    = 1'b1;
          SKIPPED = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        ALU_A      = a_q;
        ALU_B      = b_q;
        ALU_OP     = map_alu_op(op_q);
        ALU_S      = 1'b1;
        ALU_OUT_EN = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        ALU_A      = a_q;
        ALU_B      = b_q;
        ALU_OP     = map_alu_op(op_q);
        ALU_S      = 1'b1;
        ALU_OUT_EN = 1'b1;
        DONE       = 1'b1;
        if (!is_compare(op_q)) begin
          RF_WE    = 1'b1;
          RF_WADDR = rd_q;
          RF_WDATA = ALU_RESULT;
        end
        if (s_q || is_compare(op_q)) begin
          if (is_arith(op_q)) begin
            cpsr_d = ALU_FLAGS_OUT;
          end else begin
            cpsr_d = {ALU_FLAGS_OUT[FLAG_N], ALU_FLAGS_OUT[FLAG_Z], shc_q, cpsr_q[FLAG_V]};
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - directed self-checking bench for alu_exec_sequencer
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [3:0]  CMD_COND = '0;
  logic [3:0]  CMD_OPCODE = '0;
  logic        CMD_S = 1'b0;
  logic [3:0]  CMD_RD = '0;
  logic [31:0] CMD_A = '0;
  logic [31:0] CMD_B = '0;
  logic        CMD_SHIFT_C = 1'b0;
  logic [31:0] ALU_A, ALU_B;
  logic [4:0]  ALU_OP;
  logic        ALU_S, ALU_OUT_EN;
  logic [3:0]  ALU_FLAGS_IN;
  logic [31:0] ALU_RESULT;
  logic [3:0]  ALU_FLAGS_OUT;
  logic        RF_WE;
  logic [3:0]  RF_WADDR;
  logic [31:0] RF_WDATA;
  logic [3:0]  CPSR;
  logic        DONE, SKIPPED;

  int total = 0;
  int bad = 0;

  alu_exec_sequencer #(.DW(32), .RW(4)) dut (
    .clk(clk), .reset(reset),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_COND(CMD_COND),
    .CMD_OPCODE(CMD_OPCODE), .CMD_S(CMD_S), .CMD_RD(CMD_RD), .CMD_A(CMD_A),
    .CMD_B(CMD_B), .CMD_SHIFT_C(CMD_SHIFT_C),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_S(ALU_S),
    .ALU_OUT_EN(ALU_OUT_EN), .ALU_FLAGS_IN(ALU_FLAGS_IN),
    .ALU_RESULT(ALU_RESULT), .ALU_FLAGS_OUT(ALU_FLAGS_OUT),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .CPSR(CPSR), .DONE(DONE), .SKIPPED(SKIPPED)
  );

  always #5 clk = ~clk;

  // Reference ALU for the ops used below.
  logic [32:0] alu_sum;
  logic [31:0] alu_r;
  logic        alu_c, alu_v;
  always_comb begin
    alu_sum = '0;
    alu_r   = '0;
    alu_c   = ALU_FLAGS_IN[1];
    alu_v   = ALU_FLAGS_IN[0];
    case (ALU_OP)
      5'b00000, 5'b01000: alu_r = ALU_A & ALU_B;
      5'b00010, 5'b01010: begin
        alu_sum = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 33'd1;
        alu_r   = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (ALU_A[31] != ALU_B[31]) && (alu_r[31] != ALU_A[31]);
      end
      5'b00100: begin
        alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
        alu_r   = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (ALU_A[31] == ALU_B[31]) && (alu_r[31] != ALU_A[31]);
      end
      5'b10000: alu_r = ALU_B;
      default:  alu_r = '0;
    endcase
    ALU_RESULT    = ALU_OUT_EN ? alu_r : 32'd0;
    ALU_FLAGS_OUT = ALU_OUT_EN ? {alu_r[31], (alu_r == 32'd0), alu_c, alu_v} : 4'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        shc;
    logic        exp_skip;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_cpsr;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input int idx, input vec_t v);
    logic got_done = 1'b0;
    logic got_skip = 1'b0;
    logic got_we = 1'b0;
    logic [3:0] wa = '0;
    logic [31:0] wd = '0;
    int done_cyc = 0;
    @(negedge clk);
    check($sformatf("v%0d ready", idx), {31'd0, CMD_READY}, 32'd1);
    CMD_COND = v.cond; CMD_OPCODE = v.op; CMD_S = v.s; CMD_RD = v.rd;
    CMD_A = v.a; CMD_B = v.b; CMD_SHIFT_C = v.shc; CMD_VALID = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (RF_WE) begin
        got_we = 1'b1; wa = RF_WADDR; wd = RF_WDATA;
      end
      if (DONE) begin
        got_done = 1'b1; got_skip = SKIPPED; done_cyc = cyc;
        break;
      end
    end
    check($sformatf("v%0d done_seen", idx), {31'd0, got_done}, 32'd1);
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_skip ? 32'd1 : 32'd3);
    check($sformatf("v%0d skipped", idx), {31'd0, got_skip}, {31'd0, v.exp_skip});
    check($sformatf("v%0d rf_we", idx), {31'd0, got_we}, {31'd0, v.exp_we});
    if (v.exp_we) begin
      check($sformatf("v%0d waddr", idx), {28'd0, wa}, {28'd0, v.rd});
      check($sformatf("v%0d wdata", idx), wd, v.exp_wdata);
    end
    @(negedge clk);
    check($sformatf("v%0d cpsr", idx), {28'd0, CPSR}, {28'd0, v.exp_cpsr});
  endtask

  initial begin
    logic        saw_we;
    logic [15:0] ready_mask, done_mask;

    //            cond   op     s  rd  a             b             shc skip we wdata         cpsr
    vecs[0]  = '{4'hE, 4'h4, 1, 3, 32'hFFFFFFFF, 32'h00000001, 0, 0, 1, 32'h00000000, 4'b0110};
    vecs[1]  = '{4'hE, 4'hA, 0, 0, 32'h00000005, 32'h00000005, 0, 0, 0, 32'h00000000, 4'b0110};
    vecs[2]  = '{4'h1, 4'hD, 0, 2, 32'h00000000, 32'h00000007, 0, 1, 0, 32'h00000000, 4'b0110};
    vecs[3]  = '{4'hE, 4'h4, 1, 1, 32'h7FFFFFFF, 32'h00000001, 0, 0, 1, 32'h80000000, 4'b1001};
    vecs[4]  = '{4'hE, 4'h0, 1, 5, 32'h80000001, 32'h80000000, 1, 0, 1, 32'h80000000, 4'b1011};
    vecs[5]  = '{4'hA, 4'h2, 1, 6, 32'h00000003, 32'h00000005, 0, 0, 1, 32'hFFFFFFFE, 4'b1000};
    vecs[6]  = '{4'hE, 4'h4, 0, 7, 32'h0000000A, 32'h00000014, 0, 0, 1, 32'h0000001E, 4'b1000};
    vecs[7]  = '{4'h0, 4'hD, 0, 2, 32'h00000000, 32'h00000009, 0, 1, 0, 32'h00000000, 4'b1000};
    vecs[8]  = '{4'h4, 4'hD, 0, 15, 32'h00000000, 32'h00000055, 0, 0, 1, 32'h00000055, 4'b1000};
    vecs[9]  = '{4'hF, 4'h4, 1, 4, 32'h00000001, 32'h00000001, 0, 1, 0, 32'h00000000, 4'b1000};
    vecs[10] = '{4'hE, 4'h8, 0, 9, 32'h000000F0, 32'h0000000F, 0, 0, 0, 32'h00000000, 4'b0100};
    vecs[11] = '{4'hE, 4'hD, 1, 8, 32'h00000000, 32'h00000000, 1, 0, 1, 32'h00000000, 4'b0110};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cpsr", {28'd0, CPSR}, 32'd0);
    check("rst ready", {31'd0, CMD_READY}, 32'd1);
    check("rst done", {31'd0, DONE}, 32'd0);
    check("rst rf_we", {31'd0, RF_WE}, 32'd0);
    check("rst out_en", {31'd0, ALU_OUT_EN}, 32'd0);
    check("rst alu_a", ALU_A, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset in the middle of EXEC of an ADDS: nothing written, flags cleared.
    @(negedge clk);
    CMD_COND = 4'hE; CMD_OPCODE = 4'h4; CMD_S = 1'b1; CMD_RD = 4'd4;
    CMD_A = 32'd1; CMD_B = 32'd2; CMD_SHIFT_C = 1'b0; CMD_VALID = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst exec out_en", {31'd0, ALU_OUT_EN}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst cpsr", {28'd0, CPSR}, 32'd0);
    check("midrst ready", {31'd0, CMD_READY}, 32'd1);
    saw_we = 1'b0;
    @(negedge clk);
    saw_we |= RF_WE;
    reset = 1'b0;
    @(negedge clk);
    check("midrst ready after", {31'd0, CMD_READY}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      saw_we |= RF_WE;
      @(negedge clk);
    end
    check("midrst no rf_we", {31'd0, saw_we}, 32'd0);
    check("midrst cpsr after", {28'd0, CPSR}, 32'd0);

    // Back-to-back ADDs with CMD_VALID held.
    ready_mask = '0;
    done_mask = '0;
    CMD_COND = 4'hE; CMD_OPCODE = 4'h4; CMD_S = 1'b0; CMD_RD = 4'd9;
    CMD_A = 32'd1; CMD_B = 32'd1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) CMD_VALID = 1'b1;
      ready_mask[k] = CMD_READY;
      done_mask[k] = DONE;
    end
    @(negedge clk);
    CMD_VALID = 1'b0;
    check("b2b ready cycles", {16'd0, ready_mask}, 32'h0111);
    check("b2b done cycles", {16'd0, done_mask}, 32'h0888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
